// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, instruction SRAM request, and a
// one-entry hold buffer feeding ID. Optional address-error flag under IF_ADEF_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1bff_fffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_excp_adef,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        to_fs_valid;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        issue;
  logic        addr_err;

  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);

  // A redirect always issues, even while ID is stalled.
  assign issue = to_fs_valid & (fs_allowin | br_taken);

`ifdef IF_ADEF_CHECK_EN
  assign addr_err = |nextpc[1:0];
`else
  assign addr_err = 1'b0;
`endif

  assign inst_sram_en    = issue & ~addr_err;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC;
      buf_valid <= 1'b0;
      inst_buf  <= 32'd0;
    end else if (issue) begin
      fs_valid  <= 1'b1;
      fs_pc     <= nextpc;
      buf_valid <= 1'b0;
    end else if (fs_valid & fs_ready_go & ds_allowin) begin
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (fs_valid & ~buf_valid) begin
      // SRAM data is only valid the cycle after the request; keep it for the stall.
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  logic adef_q;

  always_ff @(posedge clk) begin
    if (reset)      adef_q <= 1'b0;
    else if (issue) adef_q <= addr_err;
  end

  assign fs_excp_adef = adef_q;
`else
  assign fs_excp_adef = 1'b0;
`endif

  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken & to_fs_valid;
  assign fs_to_ds_pc    = fs_pc;
  assign fs_to_ds_inst  = fs_excp_adef ? 32'd0 : (buf_valid ? inst_buf : inst_sram_rdata);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a fetch-slot model checked every cycle, plus directed
// literal checks for reset, stall, redirect, wrap and (optionally) address error.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h1bff_fffc;

  logic        clk = 1'b0;
  logic        reset, ds_allowin, br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid, fs_excp_adef, inst_sram_en, inst_sram_we;
  logic [31:0] fs_to_ds_pc, fs_to_ds_inst, inst_sram_addr, inst_sram_wdata;
  logic [31:0] rdata = 32'd0;
  logic        noise;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .br_taken(br_taken), .br_target(br_target),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
    .fs_to_ds_inst(fs_to_ds_inst), .fs_excp_adef(fs_excp_adef),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(rdata)
  );

  // SRAM whose word at every address equals the address; garbage when idle and noisy.
  always @(posedge clk) begin
    if (inst_sram_en) rdata <= inst_sram_addr;
    else if (noise)   rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [31:0] a);
`ifdef IF_ADEF_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Model: one fetch slot holding the PC it owns and whether it took an address error.
  logic        started = 1'b0;
  logic        mv = 1'b0;
  logic        mad = 1'b0;
  logic [31:0] mpc = 32'd0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      mv = 1'b0; mpc = RST_PC; mad = 1'b0;
    end else if (!mv || ds_allowin || br_taken) begin
      mv  = 1'b1;
      mpc = br_taken ? br_target : mpc + 32'd4;
      mad = misal(mpc);
    end
  end

  logic [31:0] m_next;
  logic        m_issue, m_en, m_ev;
  always @(negedge clk) begin
    if (started) begin
      m_next  = br_taken ? br_target : mpc + 32'd4;
      m_issue = !reset && (!mv || ds_allowin || br_taken);
      m_en    = m_issue && !misal(m_next);
      m_ev    = mv && !br_taken && !reset;
      chk("m_en", {31'd0, inst_sram_en}, {31'd0, m_en});
      if (m_en) chk("m_addr", inst_sram_addr, m_next);
      chk("m_valid", {31'd0, fs_to_ds_valid}, {31'd0, m_ev});
      if (m_ev) begin
        chk("m_pc", fs_to_ds_pc, mpc);
        chk("m_inst", fs_to_ds_inst, mad ? 32'd0 : mpc);
      end
      chk("m_adef", {31'd0, fs_excp_adef}, {31'd0, mad});
      chk("m_we", {31'd0, inst_sram_we}, 32'd0);
      chk("m_wdata", inst_sram_wdata, 32'd0);
    end
  end

  task automatic nc();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'd0; noise = 1'b0;
    repeat (3) @(posedge clk);
    #1; @(negedge clk);
    chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("rst_adef", {31'd0, fs_excp_adef}, 32'd0);

    nc(); reset = 1'b0;
    @(negedge clk);
    chk("first_en", {31'd0, inst_sram_en}, 32'd1);
    chk("first_addr", inst_sram_addr, 32'h1c00_0000);
    chk("first_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    nc(); @(negedge clk);
    chk("seq0_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    chk("seq0_pc", fs_to_ds_pc, 32'h1c00_0000);
    chk("seq0_inst", fs_to_ds_inst, 32'h1c00_0000);
    nc(); @(negedge clk);
    chk("seq1_pc", fs_to_ds_pc, 32'h1c00_0004);

    // Stall five cycles with pc 0x1c000008 in fs
    nc(); ds_allowin = 1'b0; noise = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) nc();
      @(negedge clk);
      chk("stall_pc", fs_to_ds_pc, 32'h1c00_0008);
      chk("stall_inst", fs_to_ds_inst, 32'h1c00_0008);
      chk("stall_en", {31'd0, inst_sram_en}, 32'd0);
    end
    nc(); ds_allowin = 1'b1; noise = 1'b0;
    @(negedge clk);
    chk("resume_en", {31'd0, inst_sram_en}, 32'd1);
    chk("resume_addr", inst_sram_addr, 32'h1c00_000c);
    chk("resume_pc", fs_to_ds_pc, 32'h1c00_0008);
    nc(); @(negedge clk);
    chk("resume_next_pc", fs_to_ds_pc, 32'h1c00_000c);

    // Redirect while fs holds 0x1c000010
    nc(); br_taken = 1'b1; br_target = 32'h1c00_0100;
    @(negedge clk);
    chk("br_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    chk("br_addr", inst_sram_addr, 32'h1c00_0100);
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("br_pc", fs_to_ds_pc, 32'h1c00_0100);
    chk("br_inst", fs_to_ds_inst, 32'h1c00_0100);

    // Redirect during a stall
    nc(); ds_allowin = 1'b0; noise = 1'b1;
    nc(); @(negedge clk);
    chk("stall2_inst", fs_to_ds_inst, 32'h1c00_0104);
    nc(); br_taken = 1'b1; br_target = 32'h1c00_0200;
    @(negedge clk);
    chk("sbr_en", {31'd0, inst_sram_en}, 32'd1);
    chk("sbr_addr", inst_sram_addr, 32'h1c00_0200);
    chk("sbr_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("sbr_pc", fs_to_ds_pc, 32'h1c00_0200);
    chk("sbr_inst", fs_to_ds_inst, 32'h1c00_0200);
    nc(); @(negedge clk);
    chk("sbr_hold_inst", fs_to_ds_inst, 32'h1c00_0200);

    // Reset in the middle of the stall
    nc(); reset = 1'b1;
    @(negedge clk);
    chk("mrst_en", {31'd0, inst_sram_en}, 32'd0);
    chk("mrst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    nc(); @(negedge clk);
    chk("mrst2_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    nc(); reset = 1'b0; ds_allowin = 1'b1; noise = 1'b0;
    @(negedge clk);
    chk("mrst_first_addr", inst_sram_addr, 32'h1c00_0000);
    nc(); @(negedge clk);
    chk("mrst_first_pc", fs_to_ds_pc, 32'h1c00_0000);

    // PC wrap
    nc(); br_taken = 1'b1; br_target = 32'hffff_fff8;
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("wrap_pc0", fs_to_ds_pc, 32'hffff_fff8);
    nc(); @(negedge clk);
    chk("wrap_pc1", fs_to_ds_pc, 32'hffff_fffc);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
    nc(); @(negedge clk);
    chk("wrap_pc2", fs_to_ds_pc, 32'h0000_0000);
    chk("wrap_inst", fs_to_ds_inst, 32'h0000_0000);

    // Redirect while fs is empty
    nc(); reset = 1'b1;
    nc(); reset = 1'b0; br_taken = 1'b1; br_target = 32'h1c00_0300;
    @(negedge clk);
    chk("idle_br_en", {31'd0, inst_sram_en}, 32'd1);
    chk("idle_br_addr", inst_sram_addr, 32'h1c00_0300);
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("idle_br_pc", fs_to_ds_pc, 32'h1c00_0300);

`ifdef IF_ADEF_CHECK_EN
    nc(); br_taken = 1'b1; br_target = 32'h1c00_0102;
    @(negedge clk);
    chk("adef_en", {31'd0, inst_sram_en}, 32'd0);
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("adef_flag", {31'd0, fs_excp_adef}, 32'd1);
    chk("adef_pc", fs_to_ds_pc, 32'h1c00_0102);
    chk("adef_inst", fs_to_ds_inst, 32'd0);
    nc(); br_taken = 1'b1; br_target = 32'h1c00_0400;
    nc(); br_taken = 1'b0;
    @(negedge clk);
    chk("adef_clear", {31'd0, fs_excp_adef}, 32'd0);
    chk("adef_clear_pc", fs_to_ds_pc, 32'h1c00_0400);
`endif

    // Mixed stalls and redirects, checked by the model
    noise = 1'b1;
    for (int i = 0; i < 80; i++) begin
      nc();
      ds_allowin = ($urandom_range(0, 3) != 0);
      br_taken   = ($urandom_range(0, 5) == 0);
      br_target  = 32'h1c00_0000 | ({20'd0, 12'($urandom_range(0, 4095))} & 32'h0000_0ffc);
    end
    nc(); br_taken = 1'b0; ds_allowin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined LoongArch core. It generates the next PC, drives the instruction SRAM, and holds the fetched instruction. It hands {pc, inst} to the decode stage over a valid/allowin handshake. The block sits between the instruction SRAM and the ID stage, takes branch redirects back from ID, and replaces the fetch portion of the multi-cycle top.

## Interface
Parameters:
- RESET_PC, 32'h1bff_fffc, value of fs_pc in reset; the first fetch address is RESET_PC+4 = 32'h1c00_0000.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_taken  in  1  redirect from ID, single-cycle pulse.
- br_target  in  32  redirect address, valid with br_taken.
- fs_to_ds_valid  out  1  {pc, inst} offered to ID.
- fs_to_ds_pc  out  32  PC of the offered instruction.
- fs_to_ds_inst  out  32  offered instruction word.
- fs_excp_adef  out  1  fetch address-error flag; see Configuration.
- inst_sram_en  out  1  fetch request.
- inst_sram_we  out  1  constant 0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  read data, valid the cycle after en.

## Operation
- Pre-IF (combinational):
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4 (32-bit, wraps mod 2^32).
  - nextpc = br_taken ? br_target : seq_pc.
- Allowin:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
- Fetch issue: inst_sram_en = to_fs_valid & (fs_allowin | br_taken), with inst_sram_addr = nextpc.
- On issue, registers update next edge: fs_valid<=1, fs_pc<=nextpc, buf_valid<=0.
- No issue while fs_valid: fs_valid<=0 when the instruction is accepted by ID; otherwise fs_valid holds.
- Hold buffer:
  - In the first cycle fs_valid=1 and ds_allowin=0 with buf_valid=0: inst_buf<=inst_sram_rdata and buf_valid<=1.
  - fs_to_ds_inst = buf_valid ? inst_buf : inst_sram_rdata.
  - Buffer is cleared on acceptance or on redirect.
- Redirect (br_taken=1):
  - The current fs entry is cancelled: not presented to ID that cycle (fs_to_ds_valid=0) and never re-presented.
  - Target fetch issues the same cycle, regardless of ds_allowin.
  - br_taken while fs_valid=0 still issues the target fetch.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.

## Timing
- Reset values: fs_valid=0, fs_pc=RESET_PC, buf_valid=0, inst_buf=0, fs_excp_adef=0.
- Outputs during reset: inst_sram_en=0, fs_to_ds_valid=0.
- First cycle after reset deasserts: en=1, addr=0x1c000000. Next cycle: fs_to_ds_valid=1, pc=0x1c000000, inst=rdata.
- Throughput: one instruction per cycle while ds_allowin=1. Latency: address to fs_to_ds_valid is 1 cycle.
- Stall: outputs hold pc and inst constant for any number of cycles. No new fetch is issued unless br_taken.
- Reset mid-stall or mid-redirect clears all state; fetch restarts at 0x1c000000.
- PC wrap: fs_pc=0xffff_fffc sequentially fetches 0x0000_0000.

## Configuration
Macro: IF_ADEF_CHECK_EN.
- Defined:
  - If nextpc[1:0]!=0 at issue time, inst_sram_en=0.
  - The entry is still loaded: fs_valid<=1, fs_pc<=nextpc, fs_excp_adef<=1.
  - fs_to_ds_inst = 0 for that entry.
  - The flag clears on the next issue.
- Undefined: fs_excp_adef is tied 0 and nextpc is used unmodified as the SRAM address.

## Test plan
- Reset release, ds_allowin=1, memory words = address:
  - fs_to_ds_pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles.
  - inst equals pc; fs_to_ds_valid stays 1.
- Stall: ds_allowin=0 for 5 cycles starting with pc=0x1c000008 in fs while the SRAM model drives random rdata after cycle 1:
  - pc and inst hold 0x1c000008 throughout; inst_sram_en=0.
  - 0x1c00000c fetched the cycle ds_allowin returns.
- Redirect: br_taken=1 with br_target=0x1c000100 while fs holds 0x1c000010:
  - fs_to_ds_valid=0 that cycle.
  - Next cycle pc=0x1c000100; 0x1c000010 is never presented.
- Redirect during stall: ds_allowin=0 and br_taken=1 with target 0x1c000200:
  - en=1, addr=0x1c000200 the same cycle.
  - The buffered instruction is discarded.
- Reset asserted mid-stall: all outputs at reset values the next cycle; the first fetch after release is 0x1c000000.
- With IF_ADEF_CHECK_EN: br_target=0x1c000102:
  - en=0 that cycle.
  - Next cycle fs_excp_adef=1, pc=0x1c000102, inst=0.
